// File: rtl/moore_seq_detector_p_if.sv
// -----------------------------------------------------------------------------
// moore_seq_detector_p_if
// Groups the serial-input controls and the detector outputs of
// moore_seq_detector_p. clk and rst stay plain ports on the detector.
//
//   en        sample enable, inp is consumed only when en=1
//   inp       serial data bit (the pattern MSB is received first)
//   overlap   1 = overlapping detection, 0 = non-overlapping
//   load      pattern load strobe
//   pat_in    new pattern, captured when load=1
//   clr_cnt   synchronous clear of match_cnt
//   det       registered Moore detect flag
//   match_len number of valid history bits, saturating at PAT_W
//   match_cnt saturating count of detections
//
// master: drives the controls (stimulus / upstream logic).
// slave : the detector itself.
// -----------------------------------------------------------------------------
interface moore_seq_detector_p_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             en;
  logic             inp;
  logic             overlap;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             clr_cnt;
  logic             det;
  logic [LEN_W-1:0] match_len;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, inp, overlap, load, pat_in, clr_cnt,
    input  det, match_len, match_cnt
  );

  modport slave (
    input  en, inp, overlap, load, pat_in, clr_cnt,
    output det, match_len, match_cnt
  );
endinterface

// File: rtl/moore_seq_detector_p.sv
// -----------------------------------------------------------------------------
// moore_seq_detector_p
// Parametrised Moore serial sequence detector. One bit is shifted in per
// enabled clock and the last PAT_W bits are compared with a runtime-loadable
// pattern. Detection is overlapping or non-overlapping under control of
// bus.overlap, and a saturating counter tallies detections.
//
// Ports:
//   clk  system clock, all logic on the rising edge
//   rst  synchronous active-low reset
//   bus  moore_seq_detector_p_if.slave (controls in, det/match_len/match_cnt out)
//
// Every output is driven straight from a flop; there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module moore_seq_detector_p #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
  parameter int               CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  moore_seq_detector_p_if.slave bus
);
  localparam int               LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] vcnt_q, vcnt_d;
  logic             det_q,  det_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Per-sample intermediates
  logic [PAT_W-1:0] hist_sh;
  logic [LEN_W-1:0] vcnt_b;
  logic             hit;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (!rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      vcnt_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    pat_d   = pat_q;
    hist_d  = hist_q;
    vcnt_d  = vcnt_q;
    det_d   = det_q;
    cnt_d   = cnt_q;
    hist_sh = {hist_q[PAT_W-2:0], bus.inp};
    vcnt_b  = vcnt_q;
    hit     = 1'b0;

    if (bus.load) begin
      // A new pattern invalidates all history; inp is ignored this cycle.
      pat_d  = bus.pat_in;
      hist_d = '0;
      vcnt_d = '0;
      det_d  = 1'b0;
    end else if (bus.en) begin
      // Non-overlapping: the bit after a hit opens a fresh window of length 1,
      // so no bit of the previous match can take part in the next one.
      if (det_q && !bus.overlap) begin
        vcnt_b = LEN_W'(1);
      end else if (vcnt_q == LEN_MAX) begin
        vcnt_b = LEN_MAX;
      end else begin
        vcnt_b = vcnt_q + LEN_W'(1);
      end
      hit    = (vcnt_b == LEN_MAX) && (hist_sh == pat_q);
      hist_d = hist_sh;
      vcnt_d = vcnt_b;
      det_d  = hit;
    end

    // The counter clear wins over a simultaneous hit, which is then lost.
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.det       = det_q;
  assign bus.match_len = vcnt_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_moore_seq_detector_p.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detector_p
// Directed, table-driven bench for moore_seq_detector_p (PAT_W=4, CNT_W=8,
// PAT_RST=4'b1011). Each record holds the inputs for one rising edge and the
// hand-computed outputs expected just after that edge. A few hand-written
// sequences cover counter saturation, clear-on-hit and back-to-back hits.
// -----------------------------------------------------------------------------
module tb_moore_seq_detector_p;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef struct {
    logic             rst;
    logic             en;
    logic             inp;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             clr_cnt;
    logic             exp_det;
    logic [LEN_W-1:0] exp_len;
    logic [CNT_W-1:0] exp_cnt;
    string            name;
  } vec_t;

  logic clk;
  logic rst;

  int n_vec  = 0;
  int n_miss = 0;

  moore_seq_detector_p_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  moore_seq_detector_p #(
    .PAT_W  (PAT_W),
    .PAT_RST(4'b1011),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic r, input logic e, input logic i,
                              input logic ov, input logic ld,
                              input logic [PAT_W-1:0] p, input logic clr,
                              input logic ed, input int el, input int ec,
                              input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.inp = i; v.overlap = ov; v.load = ld;
    v.pat_in = p; v.clr_cnt = clr; v.exp_det = ed;
    v.exp_len = LEN_W'(el); v.exp_cnt = CNT_W'(ec); v.name = nm;
    return v;
  endfunction

  task automatic check(input string name, input logic ed,
                       input logic [LEN_W-1:0] el, input logic [CNT_W-1:0] ec);
    n_vec++;
    if (bus.det !== ed || bus.match_len !== el || bus.match_cnt !== ec) begin
      n_miss++;
      $display("FAIL %s: got det=%b len=%0d cnt=%0d, want det=%b len=%0d cnt=%0d",
               name, bus.det, bus.match_len, bus.match_cnt, ed, el, ec);
    end
  endtask

  // Drive inputs on the falling edge, clock them in, then check #1 later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    bus.en      = v.en;
    bus.inp     = v.inp;
    bus.overlap = v.overlap;
    bus.load    = v.load;
    bus.pat_in  = v.pat_in;
    bus.clr_cnt = v.clr_cnt;
    @(posedge clk);
    #1;
    check(v.name, v.exp_det, v.exp_len, v.exp_cnt);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.inp = 1'b0; bus.overlap = 1'b1;
    bus.load = 1'b0; bus.pat_in = '0; bus.clr_cnt = 1'b0;

    //                   rst en inp ov ld pat      clr  det len cnt
    // Reset / defaults, then 1,0,1,1 against the reset pattern.
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "rst_a"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "rst_b"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "idle"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "def_b1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "def_b2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "def_b3"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 1, "def_hit"));
    // Overlapping: 1,0,1,1,0,1,1 -> hits after bits 4 and 7.
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "ov_rst"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "ov_b1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "ov_b2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "ov_b3"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 1, "ov_b4"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 4, 1, "ov_b5"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 4, 1, "ov_b6"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 2, "ov_b7"));
    // Non-overlapping: same stream -> one hit, window restarts at 1.
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0,  0, 0, 0, "no_rst"));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 1, 0, "no_b1"));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0,  0, 2, 0, "no_b2"));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 3, 0, "no_b3"));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0,  1, 4, 1, "no_b4"));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0,  0, 1, 1, "no_b5"));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 2, 1, "no_b6"));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 3, 1, "no_b7"));
    // Enable gating: 1,0,1, five idle cycles with inp toggling, then 1.
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "en_rst"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "en_b1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "en_b2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "en_b3"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 0,  0, 3, 0, "en_gap1"));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "en_gap2"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 0,  0, 3, 0, "en_gap3"));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "en_gap4"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 0,  0, 3, 0, "en_gap5"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 1, "en_hit"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'b0000, 0,  1, 4, 1, "en_det_hold"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 4, 1, "en_det_drop"));
    // Runtime load at match_len=2; inp=1 during load is ignored.
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "ld_rst"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "ld_b1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "ld_b2"));
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'b0110, 0,  0, 0, 0, "ld_load"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 1, 0, "ld_p1"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 2, 0, "ld_p2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "ld_p3"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  1, 4, 1, "ld_hit"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 4, 1, "ld_old1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 4, 1, "ld_old2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 4, 1, "ld_old3"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 4, 1, "ld_old4"));
    // Load together with clr_cnt clears the counter as well.
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'b0110, 1,  0, 0, 0, "ld_clr"));
    // Mid-stream reset restores PAT_RST and discards the partial match.
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "mr_b1"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "mr_b2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "mr_b3"));
    vecs.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 1,  0, 0, 0, "mr_rst"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, "mr_after"));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'b0000, 0,  0, 2, 0, "mr_p2"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  0, 3, 0, "mr_p3"));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 1, "mr_pat_rst"));

    foreach (vecs[i]) apply(vecs[i]);

    // Saturation: pattern 1111, overlap=1, 300 consecutive ones.
    // After bit k: det=1 from k=4, len=min(k,4), cnt=min(k-3,255).
    apply(mk(0, 0, 0, 1, 0, 4'b0000, 0,  0, 0, 0, "sat_rst"));
    apply(mk(1, 0, 0, 1, 1, 4'b1111, 0,  0, 0, 0, "sat_load"));
    for (int k = 1; k <= 300; k++) begin
      int el;
      int ec;
      el = (k < 4) ? k : 4;
      ec = (k < 4) ? 0 : ((k - 3 > 255) ? 255 : k - 3);
      apply(mk(1, 1, 1, 1, 0, 4'b0000, 0, (k >= 4), el, ec, $sformatf("sat_k%0d", k)));
    end
    // Clear on a hit cycle: hit is not counted; the next hit counts 1.
    apply(mk(1, 1, 1, 1, 0, 4'b0000, 1,  1, 4, 0, "clr_on_hit"));
    apply(mk(1, 1, 1, 1, 0, 4'b0000, 0,  1, 4, 1, "clr_next"));
    // Clear while idle: det holds, counter clears.
    apply(mk(1, 0, 0, 1, 0, 4'b0000, 1,  1, 4, 0, "clr_idle"));
    // Switch to non-overlap after a hit: fresh window of four ones needed.
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 1, 0, "nov_w1"));
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 2, 0, "nov_w2"));
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 3, 0, "nov_w3"));
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0,  1, 4, 1, "nov_w4"));
    apply(mk(1, 1, 1, 0, 0, 4'b0000, 0,  0, 1, 1, "nov_w5"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/moore_seq_detector_p.md
Name: moore_seq_detector_p

Overview:
Parametrised Moore-style serial sequence detector. It is the generalised successor of the team's fixed 1-bit pattern detector FSM. It accepts one serial bit per enabled clock and compares the last PAT_W bits against a runtime-loadable pattern, with selectable overlapping or non-overlapping detection. A saturating match counter is provided for link/bit-stream monitors.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16).
PAT_RST, 4'b1011, pattern value loaded at reset. The MSB of the pattern is the first bit received.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
en  input  1  sample enable; inp is consumed only when en=1
inp  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
load  input  1  pattern load strobe
pat_in  input  PAT_W  new pattern, captured when load=1
clr_cnt  input  1  synchronous clear of match_cnt
det  output  1  Moore detect flag (registered)
match_len  output  clog2(PAT_W+1)  number of valid history bits, saturating at PAT_W
match_cnt  output  CNT_W  saturating count of detections

Behaviour:
- State is the pattern register pat, history shift register hist[PAT_W-1:0], valid count vcnt (0..PAT_W), det, and match_cnt.
- Reset (rst=0 at a rising edge): pat=PAT_RST, hist=0, vcnt=0, det=0, match_cnt=0. Reset overrides every other input. This applies mid-stream as well: all partial matches are lost.
- Priority per edge: reset > load > en. clr_cnt is evaluated independently of load and en.
- load=1: pat<=pat_in, hist<=0, vcnt<=0, det<=0. inp is ignored that cycle. match_cnt is unchanged unless clr_cnt=1.
- en=0 and load=0: all state holds, including det.
- en=1 and load=0:
  - hist_n = {hist[PAT_W-2:0], inp}.
  - Base count: vcnt_b = 1 if (det=1 and overlap=0), otherwise min(vcnt+1, PAT_W).
  - hit = (vcnt_b==PAT_W) and (hist_n==pat).
  - Registered updates: hist<=hist_n, vcnt<=vcnt_b, det<=hit.
- Latency: det is high for the single cycle following the edge that samples the completing bit. It remains high longer only if en stays low, or if the next sampled bit also completes a match.
- Overlap=1: every sampled bit whose last PAT_W bits equal pat produces a hit. Hits on consecutive bits are possible, for example pattern 1111 with input 11111.
- Overlap=0: after a hit, the next sampled bit starts a fresh window with vcnt=1. A new hit therefore needs PAT_W fresh bits. Bits from the previous match are never reused.
- Changing overlap takes effect at the next sampled bit. No state is cleared.
- match_cnt:
  - clr_cnt=1: match_cnt<=0. Clear has priority over a simultaneous hit, and that hit is not counted.
  - Otherwise, on hit, match_cnt increments and saturates at 2^CNT_W-1 (no wrap).
- match_len = vcnt.
- No combinational path from inputs to outputs. All outputs are driven from flops.

Test Plan:
- Reset/defaults: hold rst=0 for 2 cycles, then release -> det=0, match_len=0, match_cnt=0, pat=4'b1011. Feed 1,0,1,1 with en=1 -> det=1 in the cycle after the 4th bit, match_cnt=1.
- Overlap vs non-overlap: stream 1,0,1,1,0,1,1.
  - overlap=1 -> det pulses after bits 4 and 7, match_cnt=2.
  - Same stream after reset with overlap=0 -> single pulse after bit 4, match_cnt=1, match_len=3 at end.
- Enable gating: stream 1,0,1 then en=0 for 5 cycles with inp toggling, then 1 -> exactly one det pulse after the final bit. match_len holds at 3 during the gap.
- Runtime load: mid-stream (match_len=2) assert load with pat_in=4'b0110 -> match_len=0, det=0. Feed 0,1,1,0 -> det=1, while 1,0,1,1 afterwards produces no hit.
- Counter saturation/clear: CNT_W=8, pattern 1111, overlap=1, 300 consecutive 1s -> match_cnt stops at 255. Assert clr_cnt on a hit cycle -> match_cnt=0, and the next hit gives 1.
- Reset mid-operation: after 1,0,1, drive rst=0 for one edge, then feed 1 -> no det. match_len=1, matching the single bit sampled since reset.
